// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types used across the datapath and its control blocks.
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

endpackage

// File: rtl/pipeline_ctrl_pkg.sv
// Pipeline control types shared between the control unit and the datapath registers.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } pctrl_state_t;

  typedef struct packed {
    logic pcEn;
    logic enIfId;
    logic enIdEx;
    logic enExMem;
    logic enMemWb;
    logic flushIfId;
    logic flushIdEx;
    logic flushExMem;
  } pctrl_t;

  localparam pctrl_t CTRL_FREEZE = '0;

  localparam pctrl_t CTRL_RESET = '{
    pcEn: 1'b0, enIfId: 1'b0, enIdEx: 1'b0, enExMem: 1'b0, enMemWb: 1'b0,
    flushIfId: 1'b1, flushIdEx: 1'b1, flushExMem: 1'b1
  };

  localparam pctrl_t CTRL_ADVANCE = '{
    pcEn: 1'b1, enIfId: 1'b1, enIdEx: 1'b1, enExMem: 1'b1, enMemWb: 1'b1,
    flushIfId: 1'b0, flushIdEx: 1'b0, flushExMem: 1'b0
  };

endpackage

// File: rtl/pipeline_control_unit_load_use_detect.sv
// Flags an ID-stage instruction that reads the destination of a load still in EX.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     dRenIdEx,
  input  regbits_t rtIdEx,
  input  regbits_t rsIfId,
  input  regbits_t rtIfId,
  output logic     ldu
);

  // Register zero never carries a real dependency.
  assign ldu = dRenIdEx && (rtIdEx != '0) && ((rtIdEx == rsIfId) || (rtIdEx == rtIfId));

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline (RUN/DWAIT/HALT).
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_control_unit
  import cpu_types_pkg::*;
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DWAIT_TIMEOUT = 0
`ifdef PIPE_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       dREN_EX_MEM,
  input  logic       dWEN_EX_MEM,
  input  logic       dREN_ID_EX,
  input  logic [4:0] Rt_ID_EX,
  input  logic [4:0] Rs_IF_ID,
  input  logic [4:0] Rt_IF_ID,
  input  logic       redirect_EX_MEM,
  input  logic       halt_MEM_WB,
  output logic       pc_en,
  output logic       enable_IF_ID,
  output logic       enable_ID_EX,
  output logic       enable_EX_MEM,
  output logic       enable_MEM_WB,
  output logic       flush_IF_ID,
  output logic       flush_ID_EX,
  output logic       flush_EX_MEM,
  output logic       halt,
  output logic       dwait_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ldu_stall_cnt,
  output logic [CNT_W-1:0] dwait_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned WD_W = 32;

  pctrl_state_t    state;
  pctrl_state_t    nextState;
  pctrl_t          flowCtrl;
  pctrl_t          ctrl;
  logic            ldu;
  logic            dmemReq;
  logic            flowApply;
  logic            wdExpire;
  logic            dwaitErr;
  logic [WD_W-1:0] wdCnt;

  load_use_detect uLoadUse (
    .dRenIdEx (dREN_ID_EX),
    .rtIdEx   (regbits_t'(Rt_ID_EX)),
    .rsIfId   (regbits_t'(Rs_IF_ID)),
    .rtIfId   (regbits_t'(Rt_IF_ID)),
    .ldu      (ldu)
  );

  assign dmemReq = dREN_EX_MEM | dWEN_EX_MEM;

  // Normal-flow priorities once memory is not blocking: redirect, load-use, imem miss.
  always_comb begin
    flowCtrl = CTRL_ADVANCE;
    if (redirect_EX_MEM) begin
      flowCtrl.flushIfId  = 1'b1;
      flowCtrl.flushIdEx  = 1'b1;
      flowCtrl.flushExMem = 1'b1;
    end else if (ldu) begin
      flowCtrl.pcEn      = 1'b0;
      flowCtrl.enIfId    = 1'b0;
      flowCtrl.flushIdEx = 1'b1;
    end else if (!ihit) begin
      flowCtrl.pcEn      = 1'b0;
      flowCtrl.flushIfId = 1'b1;
    end
  end

  // Next state and per-cycle control; halt and dmem stalls freeze everything.
  always_comb begin
    nextState = state;
    ctrl      = CTRL_FREEZE;
    flowApply = 1'b0;
    unique case (state)
      RUN: begin
        if (halt_MEM_WB) begin
          nextState = HALT;
        end else if (dmemReq && !dhit) begin
          nextState = DWAIT;
        end else begin
          flowApply = 1'b1;
        end
      end
      DWAIT: begin
        if (dhit) begin
          nextState = RUN;
          flowApply = 1'b1;
        end
      end
      HALT: begin
        nextState = HALT;
      end
      default: begin
        nextState = RUN;
      end
    endcase
    if (flowApply) begin
      ctrl = flowCtrl;
    end
    if (!nRST) begin
      ctrl = CTRL_RESET;
    end
  end

  assign wdExpire = (DWAIT_TIMEOUT != 0) && (state == DWAIT) &&
                    ((wdCnt + WD_W'(1)) == WD_W'(DWAIT_TIMEOUT));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      wdCnt    <= '0;
      dwaitErr <= 1'b0;
    end else begin
      state <= nextState;
      if (state == RUN && nextState == DWAIT) begin
        wdCnt <= '0;
      end else if (state == DWAIT && wdCnt != '1) begin
        wdCnt <= wdCnt + WD_W'(1);
      end
      if (wdExpire) begin
        dwaitErr <= 1'b1;
      end
    end
  end

  assign pc_en         = ctrl.pcEn;
  assign enable_IF_ID  = ctrl.enIfId;
  assign enable_ID_EX  = ctrl.enIdEx;
  assign enable_EX_MEM = ctrl.enExMem;
  assign enable_MEM_WB = ctrl.enMemWb;
  assign flush_IF_ID   = ctrl.flushIfId;
  assign flush_ID_EX   = ctrl.flushIdEx;
  assign flush_EX_MEM  = ctrl.flushExMem;
  assign halt          = (state == HALT);
  assign dwait_err     = dwaitErr;

`ifdef PIPE_PERF_CNT_EN
  logic lduEvt;
  logic flushEvt;

  assign lduEvt   = flowApply && !redirect_EX_MEM && ldu;
  assign flushEvt = flowApply && redirect_EX_MEM;

  // Saturating event counters, frozen once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ldu_stall_cnt <= '0;
      dwait_cnt     <= '0;
      flush_cnt     <= '0;
    end else if (state != HALT) begin
      if (lduEvt && ldu_stall_cnt != '1) begin
        ldu_stall_cnt <= ldu_stall_cnt + CNT_W'(1);
      end
      if (state == DWAIT && dwait_cnt != '1) begin
        dwait_cnt <= dwait_cnt + CNT_W'(1);
      end
      if (flushEvt && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
